// File: rtl/bram_pkg.sv
// Shared constants and width helpers for the BRAM responder.
package bram_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  // One write-enable bit per byte lane.
  function automatic int wen_width(input int data_width);
    return data_width / 8;
  endfunction

  // Byte address -> word index shift: log2 of the lane count.
  function automatic int addr_shift(input int wen_w);
    return (wen_w > 1) ? $clog2(wen_w) : 0;
  endfunction

endpackage

// File: rtl/bram_responder_if.sv
// Word-level access bus between the responder front end and its storage array.
interface bram_responder_if #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int WW = 4
) ();
  // en qualifies one access per cycle; there is no backpressure, the slave
  // always accepts. we == 0 is a read, any we bit set is a byte-lane write.
  // dout is the pre-access word, valid the cycle after en.
  logic          en;
  logic [WW-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (output en, we, addr, din, input dout);
  modport slave  (input en, we, addr, din, output dout);
endinterface

// File: rtl/bram_resp_mem.sv
// Single-port, byte-write, read-first storage array; the array itself has no reset.
module bram_resp_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int WEN_WIDTH  = 4,
  parameter int DEPTH      = 1024
) (
  input logic             clk,
  bram_responder_if.slave bus
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read-first: the registered word is the contents before this edge's write.
  always_ff @(posedge clk) begin
    if (bus.en) begin
      rdata_q <= mem_q[bus.addr];
      for (int i = 0; i < WEN_WIDTH; i++) begin
        if (bus.we[i]) begin
          mem_q[bus.addr][8*i +: 8] <= bus.din[8*i +: 8];
        end
      end
    end
  end

  assign bus.dout = rdata_q;

endmodule

// File: rtl/bram_responder.sv
// BRAM slave responder: range check, access counters, sticky error flag.
// Optional macro BRAM_RESPONDER_OUTREG_EN adds an S_Dout output register (latency 2).
module bram_responder
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WEN_WIDTH  = wen_width(DATA_WIDTH),
  parameter int DEPTH      = 1024
) (
  (* X_INTERFACE_INFO = "xilinx.com:interface:bram:1.0 BRAM_PORT CLK" *)
  input  logic                  S_Clk,
  (* X_INTERFACE_INFO = "xilinx.com:interface:bram:1.0 BRAM_PORT RST" *)
  input  logic                  S_Rst,
  (* X_INTERFACE_INFO = "xilinx.com:interface:bram:1.0 BRAM_PORT ADDR" *)
  input  logic [ADDR_WIDTH-1:0] S_Addr,
  (* X_INTERFACE_INFO = "xilinx.com:interface:bram:1.0 BRAM_PORT EN" *)
  input  logic                  S_EN,
  (* X_INTERFACE_INFO = "xilinx.com:interface:bram:1.0 BRAM_PORT DIN" *)
  input  logic [DATA_WIDTH-1:0] S_Din,
  (* X_INTERFACE_INFO = "xilinx.com:interface:bram:1.0 BRAM_PORT WE" *)
  input  logic [WEN_WIDTH-1:0]  S_WEN,
  (* X_INTERFACE_INFO = "xilinx.com:interface:bram:1.0 BRAM_PORT DOUT" *)
  output logic [DATA_WIDTH-1:0] S_Dout,
  output logic                  err_oor,
  input  logic                  err_clr,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt
);

  localparam int SHIFT = addr_shift(WEN_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  is_wr;
  logic                  acc_ok;
  logic                  acc_oor;

  logic        sel_q, sel_d;
  logic        err_q, err_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0] stage1;

  bram_responder_if #(.AW(IDX_W), .DW(DATA_WIDTH), .WW(WEN_WIDTH)) mem_bus ();

  // DEPTH is a power of two, so any set bit above the index field is out of range.
  assign word_idx = S_Addr >> SHIFT;
  assign in_range = ~|word_idx[ADDR_WIDTH-1:IDX_W];
  assign is_wr    = |S_WEN;
  assign acc_ok   = S_EN & ~S_Rst & in_range;
  assign acc_oor  = S_EN & ~in_range;

  assign mem_bus.en   = acc_ok;
  assign mem_bus.we   = S_WEN;
  assign mem_bus.addr = word_idx[IDX_W-1:0];
  assign mem_bus.din  = S_Din;

  bram_resp_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .WEN_WIDTH (WEN_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk(S_Clk),
    .bus(mem_bus)
  );

  always_comb begin
    sel_d    = sel_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (S_EN) begin
      sel_d = in_range;
    end
    if (acc_oor) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    if (acc_ok && is_wr) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
    if (acc_ok && !is_wr) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
  end

  // sel_q masks the array output: zero after reset and after out-of-range accesses.
  always_ff @(posedge S_Clk) begin
    if (S_Rst) begin
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      sel_q    <= sel_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign stage1 = sel_q ? mem_bus.dout : '0;

`ifdef BRAM_RESPONDER_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge S_Clk) begin
    if (S_Rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= stage1;
    end
  end

  assign S_Dout = dout_q;
`else
  assign S_Dout = stage1;
`endif

  assign err_oor = err_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_bram_responder.sv
// Self-checking bench for bram_responder: directed scenarios plus randomized traffic
// compared against a word-array reference model with a latency queue.
module tb_bram_responder;

  localparam int DEPTH = 1024;
`ifdef BRAM_RESPONDER_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        err_oor;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] m_dout;
  logic [31:0] m_rd;
  logic [31:0] m_wr;
  logic        m_err;

  always #5 clk = ~clk;

  bram_responder_if #(.AW(32), .DW(32), .WW(4)) bus ();

  bram_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .WEN_WIDTH (4),
    .DEPTH     (DEPTH)
  ) dut (
    .S_Clk  (clk),
    .S_Rst  (rst),
    .S_Addr (bus.addr),
    .S_EN   (bus.en),
    .S_Din  (bus.din),
    .S_WEN  (bus.we),
    .S_Dout (bus.dout),
    .err_oor(err_oor),
    .err_clr(err_clr),
    .rd_cnt (rd_cnt),
    .wr_cnt (wr_cnt)
  );

  // One clock edge of the reference behaviour.
  function automatic void model_step(input logic r, input logic en, input logic [3:0] wen,
                                     input logic [31:0] addr, input logic [31:0] din,
                                     input logic clr);
    int unsigned idx;
    logic [31:0] resp;
    idx = addr / 4;
    if (r) begin
      exp_q.delete();
      for (int k = 0; k < LAT; k++) exp_q.push_back(32'h0);
      m_rd  = 0;
      m_wr  = 0;
      m_err = 1'b0;
    end else begin
      resp = exp_q[$];
      if (en && idx < DEPTH) begin
        resp = m_mem[idx];
        if (wen != 4'h0) begin
          for (int i = 0; i < 4; i++) if (wen[i]) m_mem[idx][8*i +: 8] = din[8*i +: 8];
          m_wr = m_wr + 1;
        end else begin
          m_rd = m_rd + 1;
        end
      end else if (en) begin
        resp  = 32'h0;
        m_err = 1'b1;
      end
      if (clr && !(en && idx >= DEPTH)) m_err = 1'b0;
      exp_q.push_back(resp);
      if (exp_q.size() > LAT) void'(exp_q.pop_front());
    end
    m_dout = exp_q[0];
  endfunction

  // Drive one cycle at the falling edge, advance the model on the rising edge,
  // and return at the next falling edge with outputs settled.
  task automatic cycle(input logic r, input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] din, input logic clr);
    rst      = r;
    bus.en   = en;
    bus.we   = wen;
    bus.addr = addr;
    bus.din  = din;
    err_clr  = clr;
    @(posedge clk);
    model_step(r, en, wen, addr, din, clr);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 4'hF, 32'h14, 32'h5555_5555, 1'b0);
    checks++;
    if (bus.dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h exp %h", bus.dout, 32'h0); end
    checks++;
    if (err_oor !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_oor); end
    checks++;
    if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got rd=%h wr=%h exp 0/0", rd_cnt, wr_cnt);
    end
    // Give words 0..15 known contents for later read-first checks.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);
    checks++;
    if (wr_cnt !== 32'd16 || rd_cnt !== 32'd0) begin
      errors++; $display("FAIL preload_cnt: got rd=%0d wr=%0d exp 0/16", rd_cnt, wr_cnt);
    end
    cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (wr_cnt !== 32'd0) begin errors++; $display("FAIL rereset_cnt: got wr=%0d exp 0", wr_cnt); end
  endtask

  task automatic test_write_read();
    cycle(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (bus.dout !== m_dout) begin errors++; $display("FAIL wr_prewrite: got %h exp %h", bus.dout, m_dout); end
    cycle(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    checks++;
    if (bus.dout !== m_dout) begin errors++; $display("FAIL rd_latency: got %h exp %h", bus.dout, m_dout); end
    idle();
    checks++;
    if (bus.dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h exp %h", bus.dout, 32'hDEAD_BEEF); end
    checks++;
    if (wr_cnt !== 32'd1 || rd_cnt !== 32'd1) begin
      errors++; $display("FAIL wr_rd_cnt: got rd=%0d wr=%0d exp 1/1", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_byte_write();
    cycle(1'b0, 1'b1, 4'h1, 32'h10, 32'h0000_00AA, 1'b0);
    checks++;
    if (bus.dout !== m_dout) begin errors++; $display("FAIL bw_readfirst: got %h exp %h", bus.dout, m_dout); end
    idle();
    checks++;
    if (bus.dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bw_prewrite: got %h exp %h", bus.dout, 32'hDEAD_BEEF); end
    cycle(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    idle();
    checks++;
    if (bus.dout !== 32'hDEAD_BEAA) begin errors++; $display("FAIL bw_merge: got %h exp %h", bus.dout, 32'hDEAD_BEAA); end
  endtask

  task automatic test_oor();
    logic [31:0] wr_before;
    cycle(1'b0, 1'b1, 4'h0, 32'h1000, 32'h0, 1'b0);
    idle();
    checks++;
    if (bus.dout !== 32'h0 || err_oor !== 1'b1) begin
      errors++; $display("FAIL oor_read: got dout=%h err=%b exp 0/1", bus.dout, err_oor);
    end
    cycle(1'b0, 1'b1, 4'h0, 32'h2000, 32'h0, 1'b1);
    checks++;
    if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_clr_collide: got %b exp 1", err_oor); end
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_clr: got %b exp 0", err_oor); end
    // 0x1010 would alias word 0x10 if the index were truncated; the write must be dropped.
    wr_before = m_wr;
    cycle(1'b0, 1'b1, 4'hF, 32'h1010, 32'h0BAD_0BAD, 1'b0);
    checks++;
    if (wr_cnt !== wr_before) begin errors++; $display("FAIL oor_wr_cnt: got %0d exp %0d", wr_cnt, wr_before); end
    cycle(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b1);
    idle();
    checks++;
    if (bus.dout !== 32'hDEAD_BEAA || err_oor !== 1'b0) begin
      errors++; $display("FAIL oor_drop: got dout=%h err=%b exp %h/0", bus.dout, err_oor, 32'hDEAD_BEAA);
    end
    // Last in-range word, and low address bits ignored.
    cycle(1'b0, 1'b1, 4'hF, 32'hFFC, 32'hA5A5_5A5A, 1'b0);
    cycle(1'b0, 1'b1, 4'h0, 32'hFFF, 32'h0, 1'b0);
    idle();
    checks++;
    if (bus.dout !== 32'hA5A5_5A5A || err_oor !== 1'b0) begin
      errors++; $display("FAIL last_word: got dout=%h err=%b exp %h/0", bus.dout, err_oor, 32'hA5A5_5A5A);
    end
  endtask

  task automatic test_wrap();
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    m_wr = 32'hFFFF_FFFF;
    idle();
    checks++;
    if (wr_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h exp %h", wr_cnt, 32'hFFFF_FFFF); end
    cycle(1'b0, 1'b1, 4'hF, 32'h30, $urandom, 1'b0);
    checks++;
    if (wr_cnt !== 32'h0) begin errors++; $display("FAIL wrap: got %h exp 0", wr_cnt); end
  endtask

  task automatic test_reset_read();
    cycle(1'b0, 1'b1, 4'hF, 32'h20, 32'h1234_5678, 1'b0);
    cycle(1'b1, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    checks++;
    if (bus.dout !== 32'h0 || rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_read: got dout=%h rd=%0d wr=%0d exp 0/0/0", bus.dout, rd_cnt, wr_cnt);
    end
    idle();
    checks++;
    if (bus.dout !== 32'h0) begin errors++; $display("FAIL rst_stale: got %h exp 0", bus.dout); end
    cycle(1'b0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    idle();
    checks++;
    if (bus.dout !== 32'h1234_5678) begin errors++; $display("FAIL rst_keep: got %h exp %h", bus.dout, 32'h1234_5678); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_before;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);
      checks++;
      if (bus.dout !== m_dout) begin errors++; $display("FAIL b2b_wr%0d: got %h exp %h", i, bus.dout, m_dout); end
    end
    rd_before = m_rd;
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      if (i < 8) cycle(1'b0, 1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b0);
      else       idle();
      checks++;
      if (bus.dout !== m_dout) begin errors++; $display("FAIL b2b_rd%0d: got %h exp %h", i, bus.dout, m_dout); end
    end
    checks++;
    if (rd_cnt !== rd_before + 32'd8) begin errors++; $display("FAIL b2b_cnt: got %0d exp %0d", rd_cnt, rd_before + 32'd8); end
  endtask

  task automatic test_random();
    logic        r, en, clr;
    logic [3:0]  wen;
    logic [31:0] addr;
    for (int n = 0; n < 300; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 3) != 0);
      wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) addr = 32'h1000 + $urandom;
      else addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if (addr < 32'h1000 && addr >= 32'h40) addr = 32'h1000;
      cycle(r, en, wen, addr, $urandom, clr);
      checks++;
      if (bus.dout !== m_dout) begin errors++; $display("FAIL rnd_dout[%0d]: got %h exp %h", n, bus.dout, m_dout); end
      checks++;
      if (err_oor !== m_err || rd_cnt !== m_rd || wr_cnt !== m_wr) begin
        errors++;
        $display("FAIL rnd_state[%0d]: got err=%b rd=%0d wr=%0d exp err=%b rd=%0d wr=%0d",
                 n, err_oor, rd_cnt, wr_cnt, m_err, m_rd, m_wr);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.we   = 4'h0;
    bus.addr = 32'h0;
    bus.din  = 32'h0;
    err_clr  = 1'b0;
    m_rd     = 0;
    m_wr     = 0;
    m_err    = 1'b0;
    m_dout   = 32'h0;
    for (int k = 0; k < LAT; k++) exp_q.push_back(32'h0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_write();
    test_oor();
    test_wrap();
    test_reset_read();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
